alu_cell_sequencer: RTL and testbench

//  Issue-side controller for the ripple ALU-cell array in the RV32EC execute stage.
//  - Accepts one ALU op over a valid/ready handshake and drives operands plus shared

---
 rtl/alu_cell_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_alu_cell_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cell_sequencer.sv
// alu_cell_sequencer: issue-side controller for the ripple ALU-cell array.
// Drives operands and shared cell controls into the chain. Waits for the ripple
// to settle, then samples the chain and derives SLT/SLTU from it. Shifts run
// iteratively in the controller. The result is held until the consumer takes it.
// Optional feature macro: ALU_SHIFT_EN (iterative SLL/SRL/SRA). When it is not
// defined, ops 7-9 behave like the unused opcodes (result 0, latency 1).
module alu_cell_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] cell_a,
    output logic [WIDTH-1:0] cell_b,
    output logic             cell_inv_a,
    output logic             cell_inv_b,
    output logic             cell_or,
    output logic             cell_flood,
    output logic             cell_cin,
    input  logic [WIDTH-1:0] cell_out,
    input  logic             cell_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero
);

    localparam int SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES - 1);

`ifdef ALU_SHIFT_EN
    typedef enum logic [1:0] {Idle, Eval, Shift, Done} state_t;
`else
    typedef enum logic [1:0] {Idle, Eval, Done} state_t;
`endif

    state_t           state, nextState;
    logic [3:0]       opReg;
    logic [SetW-1:0]  settleCnt;
    logic [WIDTH-1:0] cellA, cellB, resultReg;
    logic [4:0]       ctrl;        // {inv_a, inv_b, or, flood, cin}
    logic             accept, sample;
`ifdef ALU_SHIFT_EN
    logic [4:0]       shiftCnt;
    logic             shiftStep;
`endif

    // Ops 0-6 are evaluated by the cell chain.
    function automatic logic isEvalOp(input logic [3:0] op);
        return op <= 4'd6;
    endfunction

`ifdef ALU_SHIFT_EN
    function automatic logic isShiftOp(input logic [3:0] op);
        return (op >= 4'd7) && (op <= 4'd9);
    endfunction

    // One bit position per call; SRA replicates the sign bit, which stays a[W-1].
    function automatic logic [WIDTH-1:0] shiftOnce(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] v);
        case (op)
            4'd7:    return {v[WIDTH-2:0], 1'b0};
            4'd8:    return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction
`endif

    // Shared cell control word per op: {inv_a inv_b or flood cin}.
    function automatic logic [4:0] ctrlFor(input logic [3:0] op);
        case (op)
            4'd0:             return 5'b00000;
            4'd1, 4'd5, 4'd6: return 5'b01001;
            4'd2:             return 5'b11110;
            4'd3:             return 5'b00100;
            4'd4:             return 5'b01010;
            default:          return 5'b00000;
        endcase
    endfunction

    // Turns the settled chain output into the op result. SLT corrects the
    // sign of the difference for signed overflow; SLTU uses the borrow.
    function automatic logic [WIDTH-1:0] evalResult(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] r,
                                                    input logic cout,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic ovf;
        ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (r[WIDTH-1] ^ a[WIDTH-1]);
        case (op)
            4'd5:    return {{(WIDTH-1){1'b0}}, r[WIDTH-1] ^ ovf};
            4'd6:    return {{(WIDTH-1){1'b0}}, ~cout};
            default: return r;
        endcase
    endfunction

    // State register; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= Idle;
        else        state <= nextState;
    end

    // Next-state logic and per-cycle strobes.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        sample    = 1'b0;
`ifdef ALU_SHIFT_EN
        shiftStep = 1'b0;
`endif
        case (state)
            Idle: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (isEvalOp(in_op))
                        nextState = Eval;
`ifdef ALU_SHIFT_EN
                    else if (isShiftOp(in_op) && (in_b[4:0] != 5'd0))
                        nextState = Shift;
`endif
                    else
                        nextState = Done;
                end
            end
            Eval: begin
                if (settleCnt == SettleLast) begin
                    sample    = 1'b1;
                    nextState = Done;
                end
            end
`ifdef ALU_SHIFT_EN
            Shift: begin
                shiftStep = 1'b1;
                if (shiftCnt == 5'd1) nextState = Done;
            end
`endif
            Done: begin
                if (out_ready) nextState = Idle;
            end
            default: nextState = Idle;
        endcase
    end

    // Operand/control launch, settle counting, sampling and shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opReg     <= '0;
            settleCnt <= '0;
            cellA     <= '0;
            cellB     <= '0;
            ctrl      <= '0;
            resultReg <= '0;
`ifdef ALU_SHIFT_EN
            shiftCnt  <= '0;
`endif
        end else begin
            if (accept) begin
                opReg     <= in_op;
                settleCnt <= '0;
                if (isEvalOp(in_op)) begin
                    cellA <= in_a;
                    cellB <= in_b;
                    ctrl  <= ctrlFor(in_op);
                end
`ifdef ALU_SHIFT_EN
                else if (isShiftOp(in_op)) begin
                    resultReg <= in_a;
                    shiftCnt  <= in_b[4:0];
                end
`endif
                else begin
                    resultReg <= '0;
                end
            end else if (sample) begin
                resultReg <= evalResult(opReg, cell_out, cell_cout, cellA, cellB);
                cellA     <= '0;
                cellB     <= '0;
                ctrl      <= '0;
            end else if (state == Eval) begin
                settleCnt <= settleCnt + 1'b1;
            end
`ifdef ALU_SHIFT_EN
            else if (shiftStep) begin
                resultReg <= shiftOnce(opReg, resultReg);
                shiftCnt  <= shiftCnt - 5'd1;
            end
`endif
        end
    end

    assign in_ready   = (state == Idle);
    assign out_valid  = (state == Done);
    assign out_result = resultReg;
    assign out_zero   = (state == Done) && (resultReg == '0);
    assign cell_a     = cellA;
    assign cell_b     = cellB;
    assign cell_inv_a = ctrl[4];
    assign cell_inv_b = ctrl[3];
    assign cell_or    = ctrl[2];
    assign cell_flood = ctrl[1];
    assign cell_cin   = ctrl[0];

endmodule

// File: tb/tb_alu_cell_sequencer.sv
// Bench for alu_cell_sequencer with a behavioural 32-cell ripple chain attached.
module tb_alu_cell_sequencer;

    localparam int W      = 32;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [3:0] in_op;
    logic [W-1:0] in_a, in_b, cell_a, cell_b, cell_out, out_result;
    logic cell_inv_a, cell_inv_b, cell_or, cell_flood, cell_cin, cell_cout;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    alu_cell_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .cell_a(cell_a), .cell_b(cell_b),
        .cell_inv_a(cell_inv_a), .cell_inv_b(cell_inv_b), .cell_or(cell_or),
        .cell_flood(cell_flood), .cell_cin(cell_cin),
        .cell_out(cell_out), .cell_cout(cell_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero)
    );

    // Ripple chain of ALU cells: optional operand inversion, flood forces every
    // carry input high, Or mode outputs (a|b)^carry and passes no carry on.
    always_comb begin
        logic c, ai, bi, ci;
        c = cell_cin;
        cell_out = '0;
        for (int i = 0; i < W; i++) begin
            ai = cell_a[i] ^ cell_inv_a;
            bi = cell_b[i] ^ cell_inv_b;
            ci = c | cell_flood;
            cell_out[i] = cell_or ? ((ai | bi) ^ ci) : (ai ^ bi ^ ci);
            c = cell_or ? 1'b0 : ((ai & bi) | (ai & ci) | (bi & ci));
        end
        cell_cout = c;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] expCtrl(input logic [3:0] op);
        case (op)
            4'd0:             return 5'b00000;
            4'd1, 4'd5, 4'd6: return 5'b01001;
            4'd2:             return 5'b11110;
            4'd3:             return 5'b00100;
            4'd4:             return 5'b01010;
            default:          return 5'b00000;
        endcase
    endfunction

    // Reference model: plain arithmetic on the operands.
    task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat);
        logic [4:0] sh;
        sh  = b[4:0];
        lat = SETTLE + 1;
        case (op)
            4'd0: res = a + b;
            4'd1: res = a - b;
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: res = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            4'd7: begin res = a << sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd8: begin res = a >> sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd9: begin res = $signed(a) >>> sh; lat = (sh == 0) ? 1 : sh + 1; end
`endif
            default: begin res = 32'd0; lat = 1; end
        endcase
    endtask

    // Issue one op at a negedge, measure latency, check result, optionally hold
    // out_ready low for holdCyc cycles while a competing request is presented.
    task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input int expLat, input int holdCyc,
                         input string tag);
        int lat;
        bit seen;
        int waitCnt;
        waitCnt = 0;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        check({tag, " in_ready before issue"}, 32'(in_ready), 32'd1);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        seen = 0; lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                seen = 1;
                break;
            end
            if (op <= 4'd6) begin
                check({tag, " ctrl"}, 32'({cell_inv_a, cell_inv_b, cell_or, cell_flood, cell_cin}),
                      32'(expCtrl(op)));
                check({tag, " cell_a"}, cell_a, a);
            end
        end
        if (!seen) begin
            check({tag, " out_valid timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " result"}, out_result, expRes);
        check({tag, " zero"}, 32'(out_zero), 32'(expRes == 32'd0));
        if (op > 4'd6)
            check({tag, " ctrl idle"}, 32'({cell_inv_a, cell_inv_b, cell_or, cell_flood, cell_cin}), 32'd0);
        for (int h = 0; h < holdCyc; h++) begin
            in_op = 4'd0; in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_valid = 1'b1;
            @(negedge clk);
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold result"}, out_result, expRes);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " after handshake valid"}, 32'(out_valid), 32'd0);
        check({tag, " after handshake ready"}, 32'(in_ready), 32'd1);
        if (holdCyc > 0) begin
            @(negedge clk);
            check({tag, " competing op not taken"}, 32'({out_valid, in_ready}), 32'b01);
        end
    endtask

    // Start an op, assert reset asynchronously mid-flight and check outputs.
    task automatic midReset(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int cyc, input string tag);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < cyc; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " rst in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " rst cell_a"}, cell_a, 32'd0);
        check({tag, " rst ctrl"}, 32'({cell_inv_a, cell_inv_b, cell_or, cell_flood, cell_cin}), 32'd0);
        check({tag, " rst result"}, out_result, 32'd0);
        check({tag, " rst zero"}, 32'(out_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] r, a, b;
        int lat;
        logic [3:0] op;

        vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 3};
        vecs[1]  = '{4'd1, 32'd5,         32'd7,          32'hFFFF_FFFE, 3};
        vecs[2]  = '{4'd5, 32'h8000_0000, 32'd1,          32'd1,         3};
        vecs[3]  = '{4'd6, 32'h8000_0000, 32'd1,          32'd0,         3};
        vecs[4]  = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3};
        vecs[5]  = '{4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 3};
        vecs[6]  = '{4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 3};
        vecs[7]  = '{4'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0,         3};
        vecs[8]  = '{4'd6, 32'd3,         32'hFFFF_FFFF, 32'd1,         3};
`ifdef ALU_SHIFT_EN
        vecs[9]  = '{4'd9, 32'h8000_0010, 32'd4,          32'hF800_0001, 5};
        vecs[10] = '{4'd7, 32'h1234_5678, 32'd0,          32'h1234_5678, 1};
        vecs[11] = '{4'd8, 32'h8000_0000, 32'd31,         32'd1,         32};
`else
        vecs[9]  = '{4'd9, 32'h8000_0010, 32'd4,          32'd0,         1};
        vecs[10] = '{4'd7, 32'h1234_5678, 32'd0,          32'd0,         1};
        vecs[11] = '{4'd8, 32'h8000_0000, 32'd31,         32'd0,         1};
`endif
        vecs[12] = '{4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0,        1};
        vecs[13] = '{4'd15, 32'h0000_0001, 32'h0000_0001, 32'd0,        1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", out_result, 32'd0);
        check("reset zero", 32'(out_zero), 32'd0);
        check("reset cells", cell_a | cell_b, 32'd0);
        check("reset ctrl", 32'({cell_inv_a, cell_inv_b, cell_or, cell_flood, cell_cin}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0,
                  $sformatf("vec%0d", i));

        // Consumer stalls for 10 cycles while another request is presented.
        runOp(4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 3, 10, "stall");

        // Reset during evaluation, then during a (possible) shift.
        midReset(4'd1, 32'd100, 32'd1, 1, "rstEval");
        runOp(4'd0, 32'd40, 32'd2, 32'd42, 3, 0, "postRstAdd");
        midReset(4'd8, 32'hFFFF_FFFF, 32'd20, 5, "rstShift");
`ifdef ALU_SHIFT_EN
        runOp(4'd8, 32'hFFFF_FFFF, 32'd20, 32'h0000_0FFF, 21, 0, "postRstSrl");
`else
        runOp(4'd8, 32'hFFFF_FFFF, 32'd20, 32'd0, 1, 0, "postRstSrl");
`endif
        runOp(4'd12, 32'h5, 32'h6, 32'd0, 1, 0, "op12");

        // Randomized ops against the model.
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            modelOp(op, a, b, r, lat);
            runOp(op, a, b, r, lat, 0, $sformatf("rnd%0d op%0d", n, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
